// File: rtl/seq_detect_pkg.sv
// Shared FSM state encoding and default sizing for the serial pattern detector.
package seq_detect_pkg;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_CNT_W   = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_FILL = 2'd1;
    localparam state_t ST_RUN  = 2'd2;

endpackage

// File: rtl/seq_hist_cmp.sv
// History shift register plus comparator masked to the active pattern length.
module seq_hist_cmp #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               shift_en,
    input  logic               bit_in,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   pat_len,
    output logic               hit
);

    logic [MAX_LEN-1:0] history;
    logic [MAX_LEN-1:0] hist_next;
    logic [MAX_LEN-1:0] mask;

    assign hist_next = {history[MAX_LEN-2:0], bit_in};

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(pat_len));
        end
    end

    // Compares the history as it will look after this bit is shifted in.
    assign hit = (((hist_next ^ pattern) & mask) == '0);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            history <= '0;
        end else if (shift_en) begin
            history <= hist_next;
        end
    end

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector with loadable pattern/length and overlap mode.
// Match counter is built only when SEQDET_MATCH_COUNT_EN is defined.
//
// state   | meaning
// IDLE    | no valid configuration held; input bits ignored
// FILL    | fewer than pat_len bits collected since load or last match
// RUN     | history full; every valid bit is compared
module seq_pattern_detector
    import seq_detect_pkg::*;
#(
    parameter  int MAX_LEN = DEF_MAX_LEN,
    parameter  int CNT_W   = DEF_CNT_W,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               overlap_en,
    output logic               out_detected,
    output logic               cfg_err,
    output logic [CNT_W-1:0]   match_count,
    output logic               armed
);

    state_t             state;
    logic [MAX_LEN-1:0] cfg_pat;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_ovl;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W-1:0]   fill_inc;
    logic               load_ok;
    logic               consume;
    logic               hit;
    logic               match;
    logic               hist_clear;

    assign load_ok  = (pat_len >= LEN_W'(2)) && (pat_len <= LEN_W'(MAX_LEN));
    // A load strobe, accepted or not, always swallows a coincident bit.
    assign consume  = in_valid && !cfg_load && (state != ST_IDLE);
    assign fill_inc = (fill == cfg_len) ? fill : fill + LEN_W'(1);
    assign match    = consume && (fill_inc == cfg_len) && hit;
    assign hist_clear = (cfg_load && load_ok) || (match && !cfg_ovl);
    assign armed    = (state != ST_IDLE);

    seq_hist_cmp #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_hist (
        .clk      (clk),
        .reset    (reset),
        .clear    (hist_clear),
        .shift_en (consume),
        .bit_in   (in_bit),
        .pattern  (cfg_pat),
        .pat_len  (cfg_len),
        .hit      (hit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            cfg_pat      <= '0;
            cfg_len      <= '0;
            cfg_ovl      <= 1'b0;
            fill         <= '0;
            out_detected <= 1'b0;
            cfg_err      <= 1'b0;
        end else begin
            out_detected <= match;
            cfg_err      <= cfg_load && !load_ok;
            if (cfg_load) begin
                if (load_ok) begin
                    cfg_pat <= pattern;
                    cfg_len <= pat_len;
                    cfg_ovl <= overlap_en;
                    fill    <= '0;
                    state   <= ST_FILL;
                end
            end else if (consume) begin
                if (match && !cfg_ovl) begin
                    fill  <= '0;
                    state <= ST_FILL;
                end else begin
                    fill <= fill_inc;
                    if (fill_inc == cfg_len) begin
                        state <= ST_RUN;
                    end
                end
            end
        end
    end

`ifdef SEQDET_MATCH_COUNT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (match && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign match_count = cnt;
`else
    assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed bench for seq_pattern_detector: vector table plus hand-written corner sequences.
module tb_seq_pattern_detector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1, cfg_load = 1'b0, in_valid = 1'b0, in_bit = 1'b0, overlap_en = 1'b0;
    logic [7:0] pattern = '0;
    logic [3:0] pat_len = '0;
    logic       out_detected, cfg_err, armed;
    logic [7:0] match_count;

    logic       rb = 1'b1, ldb = 1'b0, vb = 1'b0, bb = 1'b0, ovb = 1'b0;
    logic [7:0] patb = '0;
    logic [3:0] lenb = '0;
    logic       detb, errb, armb;
    logic [1:0] cntb;

    seq_pattern_detector #(.MAX_LEN(8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_load(cfg_load), .pattern(pattern), .pat_len(pat_len), .overlap_en(overlap_en),
        .out_detected(out_detected), .cfg_err(cfg_err), .match_count(match_count), .armed(armed)
    );

    seq_pattern_detector #(.MAX_LEN(8), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(rb), .in_valid(vb), .in_bit(bb),
        .cfg_load(ldb), .pattern(patb), .pat_len(lenb), .overlap_en(ovb),
        .out_detected(detb), .cfg_err(errb), .match_count(cntb), .armed(armb)
    );

    typedef struct {
        logic       r, ld, v, b;
        logic [7:0] p;
        logic [3:0] l;
        logic       ov;
        logic       e_det, e_err, e_arm;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic r, ld, v, b, input logic [7:0] p, input logic [3:0] l,
                        input logic ov, input logic e_det, e_err, e_arm, input string tag);
        @(negedge clk);
        reset = r; cfg_load = ld; in_valid = v; in_bit = b;
        pattern = p; pat_len = l; overlap_en = ov;
        @(posedge clk);
        #1;
        if (r) exp_cnt = 0;
        else if (e_det && exp_cnt < 255) exp_cnt++;
        chk({tag, "/det"}, 32'(out_detected), 32'(e_det));
        chk({tag, "/err"}, 32'(cfg_err), 32'(e_err));
        chk({tag, "/armed"}, 32'(armed), 32'(e_arm));
`ifdef SEQDET_MATCH_COUNT_EN
        chk({tag, "/count"}, 32'(match_count), 32'(exp_cnt));
`else
        chk({tag, "/count"}, 32'(match_count), 32'd0);
`endif
    endtask

    task automatic bit_step(input logic b, input logic e_det, input string tag);
        step(1'b0, 1'b0, 1'b1, b, 8'h00, 4'd0, 1'b0, e_det, 1'b0, 1'b1, tag);
    endtask

    task automatic gap_step(input logic e_arm, input string tag);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 4'd3, 1'b0, 1'b0, 1'b0, e_arm, tag);
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l, input logic ov,
                        input logic e_err, input logic e_arm, input string tag);
        step(1'b0, 1'b1, 1'b0, 1'b0, p, l, ov, 1'b0, e_err, e_arm, tag);
    endtask

    task automatic step_b(input logic r, ld, v, b, input logic e_det, input logic [1:0] e_cnt,
                          input string tag);
        @(negedge clk);
        rb = r; ldb = ld; vb = v; bb = b; patb = 8'b0000_0011; lenb = 4'd2; ovb = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "/det"}, 32'(detb), 32'(e_det));
`ifdef SEQDET_MATCH_COUNT_EN
        chk({tag, "/count"}, 32'(cntb), 32'(e_cnt));
`else
        chk({tag, "/count"}, 32'(cntb), 32'd0);
`endif
    endtask

    vec_t tbl[$];
    logic [6:0] stream = 7'b1011011;
    logic [6:0] ov_hits = 7'b0001001;
    logic [7:0] a5 = 8'hA5;
    logic [1:0] sat_cnt;

    initial begin
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 8'h0B, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0});
        for (int i = 0; i < 4; i++)
            tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 8'h0B, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1});
        for (int i = 6; i >= 0; i--)
            tbl.push_back('{1'b0, 1'b0, 1'b1, stream[i], 8'h00, 4'd0, 1'b0, ov_hits[i], 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 8'h0B, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1});
        for (int i = 6; i >= 0; i--)
            tbl.push_back('{1'b0, 1'b0, 1'b1, stream[i], 8'h00, 4'd0, 1'b0, (i == 3), 1'b0, 1'b1});

        foreach (tbl[k])
            step(tbl[k].r, tbl[k].ld, tbl[k].v, tbl[k].b, tbl[k].p, tbl[k].l, tbl[k].ov,
                 tbl[k].e_det, tbl[k].e_err, tbl[k].e_arm, $sformatf("vec%0d", k));

        // Overlap stream with idle cycles between every bit.
        load(8'h0B, 4'd4, 1'b1, 1'b0, 1'b1, "gap_load");
        for (int i = 6; i >= 0; i--) begin
            bit_step(stream[i], ov_hits[i], $sformatf("gap_bit%0d", 6 - i));
            gap_step(1'b1, $sformatf("gap_idle%0d", 6 - i));
        end

        // Reset mid-pattern, with a load and valid bit colliding with the reset.
        load(8'h0B, 4'd4, 1'b0, 1'b0, 1'b1, "rst_load");
        bit_step(1'b1, 1'b0, "rst_pre0");
        bit_step(1'b0, 1'b0, "rst_pre1");
        bit_step(1'b1, 1'b0, "rst_pre2");
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'h0B, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, "rst_hold");
        load(8'h0B, 4'd4, 1'b0, 1'b0, 1'b1, "rst_reload");
        bit_step(1'b1, 1'b0, "rst_post0");
        bit_step(1'b0, 1'b0, "rst_post1");
        bit_step(1'b1, 1'b0, "rst_post2");
        bit_step(1'b1, 1'b1, "rst_post3");

        // Rejected loads: from IDLE, then with a valid config held.
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, "rej_reset");
        load(8'h0B, 4'd9, 1'b1, 1'b1, 1'b0, "rej_idle9");
        gap_step(1'b0, "rej_idle_after");
        load(8'h0B, 4'd4, 1'b1, 1'b0, 1'b1, "rej_good");
        load(8'hFF, 4'd0, 1'b0, 1'b1, 1'b1, "rej_len0");
        gap_step(1'b1, "rej_len0_after");
        load(8'hFF, 4'd9, 1'b0, 1'b1, 1'b1, "rej_len9");
        bit_step(1'b1, 1'b0, "rej_bit0");
        bit_step(1'b0, 1'b0, "rej_bit1");
        bit_step(1'b1, 1'b0, "rej_bit2");
        bit_step(1'b1, 1'b1, "rej_bit3");

        // Load collides with a valid 1: that bit must not count toward 1,0,1,1.
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h0B, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1, "col_load");
        bit_step(1'b0, 1'b0, "col_bit0");
        bit_step(1'b1, 1'b0, "col_bit1");
        bit_step(1'b1, 1'b0, "col_bit2");
        bit_step(1'b0, 1'b0, "col_bit3");
        bit_step(1'b1, 1'b0, "col_bit4");
        bit_step(1'b1, 1'b1, "col_bit5");

        // Full-length pattern.
        load(8'hA5, 4'd8, 1'b0, 1'b0, 1'b1, "a5_load");
        for (int i = 7; i >= 0; i--)
            bit_step(a5[i], (i == 0), $sformatf("a5_bit%0d", 7 - i));

        // Two-bit counter saturation on the second instance.
        step_b(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, "sat_reset");
        step_b(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, "sat_load");
        sat_cnt = 2'd0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0 && sat_cnt != 2'd3) sat_cnt = sat_cnt + 2'd1;
            step_b(1'b0, 1'b0, 1'b1, 1'b1, (i > 0), sat_cnt, $sformatf("sat_bit%0d", i));
        end
        chk("sat_armed", 32'(armb), 32'd1);
        chk("sat_err", 32'(errb), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
